// File: rtl/kicp_sram_arbiter.sv
// kicp_sram_arbiter: shares one single-port SRAM macro between NUM_CH
// request/acknowledge channels. Channel 0 (Wishbone control) has strict
// priority, bounded by a starvation guard. The compute cores on channels
// 1..NUM_CH-1 share the remaining slots round-robin.

`ifndef KICP_SRAM_AWIDTH
`define KICP_SRAM_AWIDTH 12
`endif

module kicp_sram_arbiter #(
  parameter int NUM_CH       = 3,
  parameter int AWIDTH       = `KICP_SRAM_AWIDTH,
  parameter int DWIDTH       = 32,
  parameter int READ_LAT     = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_CH-1:0]          req,
  input  logic [NUM_CH-1:0]          we,
  input  logic [NUM_CH*DWIDTH/8-1:0] be,
  input  logic [NUM_CH*32-1:0]       addr,
  input  logic [NUM_CH*DWIDTH-1:0]   wdata,
  output logic [NUM_CH-1:0]          ack,
  output logic [DWIDTH-1:0]          rdata,
  output logic                       err,
  output logic                       busy,
  output logic                       sram_en,
  output logic [DWIDTH/8-1:0]        sram_we,
  output logic [AWIDTH-1:0]          sram_addr,
  output logic [DWIDTH-1:0]          sram_data_i,
  input  logic [DWIDTH-1:0]          sram_data_o
);

  localparam int BW = DWIDTH / 8;
  localparam int CW = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;
  localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam int LW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [LW-1:0] LAT_LAST   = LW'(READ_LAT - 1);
  localparam logic [CW-1:0] CH_FIRST   = CW'(1);
  localparam logic [CW-1:0] CH_LAST    = CW'(NUM_CH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       ch_q, ch_d;
  logic                we_q, we_d;
  logic [BW-1:0]       be_q, be_d;
  logic [AWIDTH-1:0]   addr_q, addr_d;
  logic [DWIDTH-1:0]   wdata_q, wdata_d;
  logic [DWIDTH-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [LW-1:0]       latCnt_q, latCnt_d;
  logic [CW-1:0]       rrPtr_q, rrPtr_d;
  logic [SW-1:0]       starveCnt_q, starveCnt_d;

  logic                othersPending;
  logic                ch0Wins;
  logic                rrFound;
  logic                grantValid;
  logic [CW-1:0]       rrWinner;
  logic [CW-1:0]       winner;
  logic [31:0]         selAddr;

  // Maps a search offset from the round-robin pointer onto channels 1..NUM_CH-1.
  function automatic logic [CW-1:0] rrCandidate(input logic [CW-1:0] start, input int offset);
    int idx;
    idx = int'(start) - 1 + offset;
    if (idx >= NUM_CH - 1) idx = idx - (NUM_CH - 1);
    return CW'(idx + 1);
  endfunction

  // Picks the winning channel: channel 0 unless it is starving others, else round-robin.
  always_comb begin
    othersPending = |req[NUM_CH-1:1];
    ch0Wins       = req[0] && !(othersPending && (starveCnt_q == STARVE_MAX));
    rrFound       = 1'b0;
    rrWinner      = rrPtr_q;
    for (int i = 0; i < NUM_CH - 1; i++) begin
      if (!rrFound && req[rrCandidate(rrPtr_q, i)]) begin
        rrFound  = 1'b1;
        rrWinner = rrCandidate(rrPtr_q, i);
      end
    end
    grantValid = ch0Wins || rrFound;
    winner     = ch0Wins ? '0 : rrWinner;
    selAddr    = addr[int'(winner)*32 +: 32];
  end

  // Next-state logic for the access sequence and the arbitration bookkeeping.
  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    we_d        = we_q;
    be_d        = be_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    latCnt_d    = latCnt_q;
    rrPtr_d     = rrPtr_q;
    starveCnt_d = starveCnt_q;

    unique case (state_q)
      IDLE: begin
        if (grantValid) begin
          ch_d    = winner;
          we_d    = we[winner];
          be_d    = be[int'(winner)*BW +: BW];
          addr_d  = selAddr[AWIDTH-1:0];
          wdata_d = wdata[int'(winner)*DWIDTH +: DWIDTH];
          rdata_d = '0;
          if ((selAddr >> AWIDTH) == 32'd0) begin
            state_d = ISSUE;
            err_d   = 1'b0;
          end else begin
            state_d = RESP;
            err_d   = 1'b1;
          end
          if (ch0Wins) begin
            if (!othersPending) begin
              starveCnt_d = '0;
            end else if (starveCnt_q != STARVE_MAX) begin
              starveCnt_d = starveCnt_q + 1'b1;
            end
          end else begin
            starveCnt_d = '0;
            rrPtr_d     = (winner == CH_LAST) ? CH_FIRST : winner + 1'b1;
          end
        end
      end
      ISSUE: begin
        state_d  = WAIT;
        latCnt_d = '0;
      end
      WAIT: begin
        if (latCnt_q == LAT_LAST) begin
          state_d = RESP;
          rdata_d = we_q ? '0 : sram_data_o;
        end else begin
          latCnt_d = latCnt_q + 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
        rdata_d = '0;
        err_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any access in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      ch_q        <= '0;
      we_q        <= 1'b0;
      be_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      latCnt_q    <= '0;
      rrPtr_q     <= CH_FIRST;
      starveCnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      we_q        <= we_d;
      be_q        <= be_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      latCnt_q    <= latCnt_d;
      rrPtr_q     <= rrPtr_d;
      starveCnt_q <= starveCnt_d;
    end
  end

  // SRAM strobes exist only in ISSUE and the ack pulse only in RESP, so both fall with reset.
  always_comb begin
    ack         = '0;
    sram_en     = 1'b0;
    sram_we     = '0;
    sram_addr   = '0;
    sram_data_i = '0;
    if (state_q == RESP) begin
      ack[ch_q] = 1'b1;
    end
    if (state_q == ISSUE) begin
      sram_en     = 1'b1;
      sram_we     = we_q ? be_q : '0;
      sram_addr   = addr_q;
      sram_data_i = wdata_q;
    end
  end

  assign rdata = rdata_q;
  assign err   = err_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_kicp_sram_arbiter.sv
// tb_kicp_sram_arbiter: directed checks of the SRAM arbiter. Instance 0 uses
// READ_LAT=1 and instance 1 uses READ_LAT=3. Both use AWIDTH=8 and 3 channels.
// Each instance has its own behavioural SRAM with a read pipeline.

module tb_kicp_sram_arbiter;

  logic        clk;
  logic        reset;

  logic [2:0]  reqBus      [2];
  logic [2:0]  weBus       [2];
  logic [11:0] beBus       [2];
  logic [95:0] addrBus     [2];
  logic [95:0] wdataBus    [2];
  logic [2:0]  ack         [2];
  logic [31:0] rdata       [2];
  logic        err         [2];
  logic        busy        [2];
  logic        sramEn      [2];
  logic [3:0]  sramWe      [2];
  logic [7:0]  sramAddr    [2];
  logic [31:0] sramDataIn  [2];
  logic [31:0] sramDataOut [2];

  logic [31:0] mem    [2][256];
  logic [31:0] rdPipe [2][3];
  logic        memLoaded = 1'b0;
  logic [31:0] refMem [256];

  int          checkCount = 0;
  int          errorCount = 0;
  int          ackCountA  = 0;

  int          lastEnCount;
  logic [7:0]  lastEnAddr;
  logic [3:0]  lastEnWe;
  logic [31:0] lastEnData;

  kicp_sram_arbiter #(
    .NUM_CH(3), .AWIDTH(8), .DWIDTH(32), .READ_LAT(1), .STARVE_LIMIT(4)
  ) dutA (
    .clk(clk), .reset(reset),
    .req(reqBus[0]), .we(weBus[0]), .be(beBus[0]), .addr(addrBus[0]), .wdata(wdataBus[0]),
    .ack(ack[0]), .rdata(rdata[0]), .err(err[0]), .busy(busy[0]),
    .sram_en(sramEn[0]), .sram_we(sramWe[0]), .sram_addr(sramAddr[0]),
    .sram_data_i(sramDataIn[0]), .sram_data_o(sramDataOut[0])
  );

  kicp_sram_arbiter #(
    .NUM_CH(3), .AWIDTH(8), .DWIDTH(32), .READ_LAT(3), .STARVE_LIMIT(4)
  ) dutB (
    .clk(clk), .reset(reset),
    .req(reqBus[1]), .we(weBus[1]), .be(beBus[1]), .addr(addrBus[1]), .wdata(wdataBus[1]),
    .ack(ack[1]), .rdata(rdata[1]), .err(err[1]), .busy(busy[1]),
    .sram_en(sramEn[1]), .sram_we(sramWe[1]), .sram_addr(sramAddr[1]),
    .sram_data_i(sramDataIn[1]), .sram_data_o(sramDataOut[1])
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAMs: byte-masked writes; read data runs through a pipeline whose depth is the read latency.
  always @(posedge clk) begin
    if (!memLoaded) begin
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < 256; i++) mem[k][i] <= 32'(i) * 32'h9E3779B1;
      end
      mem[0][8'h10] <= 32'hDEADBEEF;
      mem[0][8'h20] <= 32'hFFFFFFFF;
      memLoaded <= 1'b1;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (sramEn[k]) begin
          rdPipe[k][0] <= mem[k][sramAddr[k]];
          for (int b = 0; b < 4; b++) begin
            if (sramWe[k][b]) mem[k][sramAddr[k]][b*8 +: 8] <= sramDataIn[k][b*8 +: 8];
          end
        end
        rdPipe[k][1] <= rdPipe[k][0];
        rdPipe[k][2] <= rdPipe[k][1];
      end
    end
  end

  assign sramDataOut[0] = rdPipe[0][0];
  assign sramDataOut[1] = rdPipe[1][2];

  // Counts every ack pulse on instance 0, used to prove an abandoned access stays silent.
  always @(posedge clk) begin
    if (ack[0] != 3'b000) ackCountA <= ackCountA + 1;
  end

  // Hard stop if the bench ever wedges.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h required 0x%0h", tag, observed, expected);
    end
  endtask

  // Issues one request and follows it to its ack, checking latency, ack, rdata, err and SRAM strobes.
  task automatic applyStimulus(input int inst, input int ch, input bit wr, input logic [3:0] bmask,
                               input logic [31:0] a, input logic [31:0] d, input int expLat,
                               input logic [31:0] expRdata, input bit expErr, input string tag);
    int          lat;
    logic [2:0]  ackSeen;
    logic [31:0] rdSeen;
    logic        errSeen;
    bit          gotAck;
    @(negedge clk);
    weBus[inst][ch]             = wr;
    beBus[inst][ch*4 +: 4]      = bmask;
    addrBus[inst][ch*32 +: 32]  = a;
    wdataBus[inst][ch*32 +: 32] = d;
    reqBus[inst][ch]            = 1'b1;
    @(posedge clk);
    lat = 0; gotAck = 1'b0; ackSeen = '0; rdSeen = '0; errSeen = 1'b0; lastEnCount = 0;
    for (int k = 1; k <= 20 && !gotAck; k++) begin
      @(negedge clk);
      if (sramEn[inst]) begin
        lastEnCount++;
        lastEnAddr = sramAddr[inst];
        lastEnWe   = sramWe[inst];
        lastEnData = sramDataIn[inst];
      end
      if (ack[inst] != 3'b000) begin
        gotAck  = 1'b1;
        lat     = k;
        ackSeen = ack[inst];
        rdSeen  = rdata[inst];
        errSeen = err[inst];
      end
    end
    reqBus[inst][ch] = 1'b0;
    checkOutput({tag, " latency"}, 64'(lat), 64'(expLat));
    checkOutput({tag, " ack"}, 64'(ackSeen), 64'(3'b001 << ch));
    checkOutput({tag, " rdata"}, 64'(rdSeen), 64'(expRdata));
    checkOutput({tag, " err"}, 64'(errSeen), 64'(expErr));
    checkOutput({tag, " sram_en cycles"}, 64'(lastEnCount), expErr ? 64'd0 : 64'd1);
  endtask

  task automatic resetPulse();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  logic [2:0]  grantLog [10];
  logic [2:0]  expOrder [10];
  int          granted;
  int          ackBase;
  int          rch;
  bit          rwr;
  logic [3:0]  rbm;
  logic [31:0] ra;
  logic [31:0] rd;
  logic [31:0] rexp;

  initial begin
    expOrder = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b001, 3'b001, 3'b001, 3'b001, 3'b100};
    for (int i = 0; i < 256; i++) refMem[i] = 32'(i) * 32'h9E3779B1;
    for (int k = 0; k < 2; k++) begin
      reqBus[k] = '0; weBus[k] = '0; beBus[k] = '0; addrBus[k] = '0; wdataBus[k] = '0;
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] reset state");
    for (int k = 0; k < 2; k++) begin
      checkOutput("reset ctl", {ack[k], err[k], busy[k], sramEn[k], sramWe[k], sramAddr[k]}, 64'd0);
      checkOutput("reset data", {rdata[k], sramDataIn[k]}, 64'd0);
    end
    reset = 1'b1;
    @(negedge clk);

    $display("[TB] single read");
    applyStimulus(0, 1, 1'b0, 4'hF, 32'h10, 32'h0, 3, 32'hDEADBEEF, 1'b0, "read10");
    checkOutput("read10 sram_addr", 64'(lastEnAddr), 64'h10);
    checkOutput("read10 sram_we", 64'(lastEnWe), 64'h0);
    @(negedge clk);
    checkOutput("rdata cleared", 64'(rdata[0]), 64'h0);

    $display("[TB] byte write and readback");
    applyStimulus(0, 2, 1'b1, 4'b0101, 32'h20, 32'h11223344, 3, 32'h0, 1'b0, "bytewr");
    checkOutput("bytewr sram_we", 64'(lastEnWe), 64'b0101);
    checkOutput("bytewr sram_addr", 64'(lastEnAddr), 64'h20);
    checkOutput("bytewr sram_data_i", 64'(lastEnData), 64'h11223344);
    applyStimulus(0, 2, 1'b0, 4'hF, 32'h20, 32'h0, 3, 32'hFF22FF44, 1'b0, "readback");

    $display("[TB] zero byte-enable write");
    applyStimulus(0, 1, 1'b1, 4'b0000, 32'h20, 32'hAAAAAAAA, 3, 32'h0, 1'b0, "be0wr");
    checkOutput("be0wr sram_we", 64'(lastEnWe), 64'h0);
    applyStimulus(0, 1, 1'b0, 4'hF, 32'h20, 32'h0, 3, 32'hFF22FF44, 1'b0, "be0readback");

    $display("[TB] address error");
    applyStimulus(0, 1, 1'b0, 4'hF, 32'h100, 32'h0, 1, 32'h0, 1'b1, "adderr");
    applyStimulus(0, 0, 1'b1, 4'hF, 32'h8000_0000, 32'h1, 1, 32'h0, 1'b1, "adderrhi");

    $display("[TB] reset mid-access");
    @(negedge clk);
    weBus[0][1] = 1'b0;
    addrBus[0][63:32] = 32'h10;
    reqBus[0][1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("midrst issue en", 64'(sramEn[0]), 64'd1);
    @(negedge clk);
    checkOutput("midrst wait busy", 64'(busy[0]), 64'd1);
    ackBase = ackCountA;
    reset = 1'b0;
    #1;
    checkOutput("midrst ctl", {ack[0], err[0], busy[0], sramEn[0], sramWe[0], sramAddr[0]}, 64'd0);
    checkOutput("midrst data", {rdata[0], sramDataIn[0]}, 64'd0);
    reqBus[0][1] = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("midrst no ack", 64'(ackCountA - ackBase), 64'd0);
    applyStimulus(0, 1, 1'b0, 4'hF, 32'h10, 32'h0, 3, 32'hDEADBEEF, 1'b0, "postrst");

    $display("[TB] contention");
    resetPulse();
    for (int c = 0; c < 3; c++) begin
      weBus[0][c] = 1'b0;
      addrBus[0][c*32 +: 32] = 32'(c);
    end
    reqBus[0] = 3'b111;
    granted = 0;
    for (int k = 0; k < 200 && granted < 10; k++) begin
      @(negedge clk);
      if (ack[0] != 3'b000) begin
        grantLog[granted] = ack[0];
        granted++;
      end
    end
    reqBus[0] = 3'b000;
    checkOutput("contention grants", 64'(granted), 64'd10);
    for (int g = 0; g < 10; g++) begin
      checkOutput($sformatf("grant %0d", g), 64'(grantLog[g]), 64'(expOrder[g]));
    end
    repeat (2) @(negedge clk);

    $display("[TB] READ_LAT=3 sweep");
    for (int n = 0; n < 14; n++) begin
      rch = $urandom_range(0, 2);
      rwr = 1'($urandom_range(0, 1));
      rbm = 4'($urandom_range(0, 15));
      ra  = 32'($urandom_range(0, 7));
      rd  = $urandom;
      if (rwr) begin
        rexp = 32'h0;
        for (int b = 0; b < 4; b++) begin
          if (rbm[b]) refMem[ra][b*8 +: 8] = rd[b*8 +: 8];
        end
      end else begin
        rexp = refMem[ra];
      end
      applyStimulus(1, rch, rwr, rbm, ra, rd, 5, rexp, 1'b0, $sformatf("sweep%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
